// File: rtl/fsm_mon_pkg.sv
// -----------------------------------------------------------------------------
// fsm_mon_pkg
// Shared types and widths for the FSM transition monitor.
//   STATE_W / DWELL_W : default widths of the monitored state and dwell counter
//   DROP_CNT_W        : width of the saturating dropped-event counter
//   fsm_mon_evt_t     : one transition event as stored in the event FIFO
// -----------------------------------------------------------------------------
package fsm_mon_pkg;

   localparam int STATE_W    = 2;
   localparam int DWELL_W    = 8;
   localparam int DROP_CNT_W = 8;

   typedef struct packed {
      logic [STATE_W-1:0] from;
      logic [STATE_W-1:0] to;
      logic [DWELL_W-1:0] dwell;
      logic               lost;
   } fsm_mon_evt_t;

endpackage

// File: rtl/fsm_mon_fifo.sv
// -----------------------------------------------------------------------------
// fsm_mon_fifo
// Synchronous first-word-fall-through FIFO of fsm_mon_evt_t.
//   clk, rst : clock, synchronous active-high reset (empties the FIFO)
//   push/din : write request and data; ignored when full unless a pop
//              happens in the same cycle
//   full     : all DEPTH entries occupied
//   pop      : read request; ignored when empty
//   dout     : head entry, driven combinationally from storage
//   empty    : no entries held
// -----------------------------------------------------------------------------
module fsm_mon_fifo
   import fsm_mon_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  fsm_mon_evt_t din,
   output logic         full,
   input  logic         pop,
   output fsm_mon_evt_t dout,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   fsm_mon_evt_t  mem [DEPTH];
   logic [AW:0]   wr_ptr_reg;
   logic [AW:0]   rd_ptr_reg;
   logic          do_push;
   logic          do_pop;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign empty   = (wr_ptr_reg == rd_ptr_reg);
   assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign do_pop  = pop && !empty;
   // A simultaneous pop frees the head slot, so a push into a full FIFO is legal.
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
   end

   // Storage is not reset; the empty flag masks stale contents.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
      always_ff @(posedge clk) begin
         if (do_push && (wr_ptr_reg[AW-1:0] == gi[AW-1:0])) mem[gi] <= din;
      end
   end

   assign dout = mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/fsm_transition_monitor.sv
// -----------------------------------------------------------------------------
// fsm_transition_monitor
// Watches state/next_state of an FSM and queues one event per state change
// (from, to, cycles spent in from incl. the exit cycle) behind valid/ready.
// Purely observational.
//   clk, rst        : clock, synchronous active-high reset
//   state           : current FSM state
//   next_state      : FSM next state
//   enable          : capture enable (dwell holds, no events while low);
//                     the FIFO keeps draining regardless
//   evt_valid/ready : head-of-FIFO handshake
//   evt_from/to     : head event states
//   evt_dwell       : head event dwell (saturating)
//   evt_lost        : one or more events were dropped just before this one
//   drop_cnt        : saturating count of dropped events
//   timeout         : sticky stuck-state flag
// Optional feature macro: FSM_MON_TIMEOUT_EN enables the timeout comparator;
// without it timeout is tied low.
// -----------------------------------------------------------------------------
module fsm_transition_monitor
   import fsm_mon_pkg::*;
#(
   parameter int STATE_W    = 2,
   parameter int DWELL_W    = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 200
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STATE_W-1:0] state,
   input  logic [STATE_W-1:0] next_state,
   input  logic               enable,
   output logic               evt_valid,
   input  logic               evt_ready,
   output logic [STATE_W-1:0] evt_from,
   output logic [STATE_W-1:0] evt_to,
   output logic [DWELL_W-1:0] evt_dwell,
   output logic               evt_lost,
   output logic [7:0]         drop_cnt,
   output logic               timeout
);

   logic [DWELL_W-1:0]    dwell_reg, dwell_next, dwell_inc;
   logic [DROP_CNT_W-1:0] drop_reg, drop_next;
   logic                  lost_pend_reg, lost_pend_next;
   logic                  trans, pop_fire, push_ok, drop;
   logic                  fifo_full, fifo_empty;
   fsm_mon_evt_t          evt_in, head;

   assign trans     = enable && (state != next_state);
   assign dwell_inc = (dwell_reg == '1) ? dwell_reg : dwell_reg + 1'b1;
   assign pop_fire  = !fifo_empty && evt_ready;
   assign push_ok   = trans && (!fifo_full || pop_fire);
   assign drop      = trans && fifo_full && !pop_fire;

   always_comb begin
      evt_in.from  = state;
      evt_in.to    = next_state;
      evt_in.dwell = dwell_inc;
      evt_in.lost  = lost_pend_reg;
   end

   always_comb begin
      dwell_next     = dwell_reg;
      drop_next      = drop_reg;
      lost_pend_next = lost_pend_reg;
      if (enable) dwell_next = trans ? '0 : dwell_inc;
      if (push_ok) lost_pend_next = 1'b0;
      if (drop) begin
         lost_pend_next = 1'b1;
         if (drop_reg != '1) drop_next = drop_reg + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dwell_reg     <= '0;
         drop_reg      <= '0;
         lost_pend_reg <= 1'b0;
      end else begin
         dwell_reg     <= dwell_next;
         drop_reg      <= drop_next;
         lost_pend_reg <= lost_pend_next;
      end
   end

   fsm_mon_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (trans),
      .din   (evt_in),
      .full  (fifo_full),
      .pop   (evt_ready),
      .dout  (head),
      .empty (fifo_empty)
   );

   // Head fields are forced to zero while empty so reset shows clean outputs.
   assign evt_valid = !fifo_empty;
   assign evt_from  = fifo_empty ? '0   : head.from;
   assign evt_to    = fifo_empty ? '0   : head.to;
   assign evt_dwell = fifo_empty ? '0   : head.dwell;
   assign evt_lost  = fifo_empty ? 1'b0 : head.lost;
   assign drop_cnt  = drop_reg;

`ifdef FSM_MON_TIMEOUT_EN
   logic           timeout_reg;
   logic [DWELL_W:0] dwell_plus1;

   if (TIMEOUT > (2**DWELL_W) - 1) begin : g_timeout_chk
      $error("TIMEOUT must not exceed the saturated dwell value");
   end

   // Unsaturated dwell+1 so the compare is exact even at the counter limit.
   assign dwell_plus1 = {1'b0, dwell_reg} + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         timeout_reg <= 1'b0;
      end else if (trans) begin
         timeout_reg <= 1'b0;
      end else if (enable && (dwell_plus1 == TIMEOUT[DWELL_W:0])) begin
         timeout_reg <= 1'b1;
      end
   end

   assign timeout = timeout_reg;
`else
   assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_fsm_transition_monitor.sv
// -----------------------------------------------------------------------------
// tb_fsm_transition_monitor
// Directed scenarios followed by randomized traffic, checked against a
// queue-based model of the event stream.
// -----------------------------------------------------------------------------
module tb_fsm_transition_monitor;

   localparam int DEPTH   = 4;
   localparam int SAT     = 255;
   localparam int TIMEOUT = 200;

   typedef struct {
      logic [1:0] from;
      logic [1:0] to;
      int         dwell;
      bit         lost;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] state, next_state;
   logic       enable, evt_valid, evt_ready, evt_lost, timeout;
   logic [1:0] evt_from, evt_to;
   logic [7:0] evt_dwell, drop_cnt;

   int  passed = 0;
   int  fails  = 0;
   int  total  = 0;

   ev_t        q[$];
   int         m_dwell, m_drop;
   bit         m_lost, m_timeout;
   logic [1:0] cur;

   always #5 clk = ~clk;

   fsm_transition_monitor dut (
      .clk        (clk),
      .rst        (rst),
      .state      (state),
      .next_state (next_state),
      .enable     (enable),
      .evt_valid  (evt_valid),
      .evt_ready  (evt_ready),
      .evt_from   (evt_from),
      .evt_to     (evt_to),
      .evt_dwell  (evt_dwell),
      .evt_lost   (evt_lost),
      .drop_cnt   (drop_cnt),
      .timeout    (timeout)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic compare_model(input string tag);
      check({tag, ".valid"}, 32'(evt_valid), 32'(q.size() > 0));
      check({tag, ".drop"}, 32'(drop_cnt), 32'(m_drop));
      check({tag, ".timeout"}, 32'(timeout), 32'(m_timeout));
      if (q.size() > 0) begin
         check({tag, ".from"}, 32'(evt_from), 32'(q[0].from));
         check({tag, ".to"}, 32'(evt_to), 32'(q[0].to));
         check({tag, ".dwell"}, 32'(evt_dwell), 32'(q[0].dwell));
         check({tag, ".lost"}, 32'(evt_lost), 32'(q[0].lost));
      end
   endtask

   // One clock cycle: drive, check current outputs, advance the model.
   task automatic step(input string tag, input logic [1:0] nst, input logic en, input logic rdy);
      ev_t e;
      int  sz;
      bit  pop, tr;
      state      = cur;
      next_state = nst;
      enable     = en;
      evt_ready  = rdy;
      #1;
      compare_model(tag);
      sz  = q.size();
      pop = (sz > 0) && rdy;
      tr  = en && (cur != nst);
      e.from  = cur;
      e.to    = nst;
      e.dwell = (m_dwell + 1 > SAT) ? SAT : m_dwell + 1;
      e.lost  = m_lost;
`ifdef FSM_MON_TIMEOUT_EN
      if (tr) m_timeout = 1'b0;
      else if (en && (m_dwell + 1 == TIMEOUT)) m_timeout = 1'b1;
`endif
      if (pop) void'(q.pop_front());
      if (tr) begin
         if (sz < DEPTH || pop) begin
            q.push_back(e);
            m_lost = 1'b0;
         end else begin
            m_lost = 1'b1;
            if (m_drop < SAT) m_drop++;
         end
      end
      if (en) m_dwell = tr ? 0 : ((m_dwell < SAT) ? m_dwell + 1 : SAT);
      @(posedge clk);
      @(negedge clk);
      cur = nst;
      $display("step %-6s st=%0d nst=%0d en=%0b rdy=%0b -> qlen=%0d drop=%0d", tag, state, nst, en, rdy, q.size(), m_drop);
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      enable    = 1'b0;
      evt_ready = 1'b0;
      state     = cur;
      next_state = cur;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      q.delete();
      m_dwell = 0; m_drop = 0; m_lost = 1'b0; m_timeout = 1'b0;
      $display("reset applied");
   endtask

   initial begin
      cur = 2'd0;
      @(negedge clk);
      do_reset();
      check("rst.valid", 32'(evt_valid), 0);
      check("rst.from", 32'(evt_from), 0);
      check("rst.to", 32'(evt_to), 0);
      check("rst.dwell", 32'(evt_dwell), 0);
      check("rst.lost", 32'(evt_lost), 0);
      check("rst.drop", 32'(drop_cnt), 0);
      check("rst.timeout", 32'(timeout), 0);

      // 1: three idle cycles then 0->1, dwell 4
      for (int i = 0; i < 3; i++) step("t1", 2'd0, 1'b1, 1'b1);
      step("t1", 2'd1, 1'b1, 1'b0);
      check("t1.valid", 32'(evt_valid), 1);
      check("t1.dwell", 32'(evt_dwell), 4);
      check("t1.to", 32'(evt_to), 1);
      step("t1", 2'd1, 1'b1, 1'b1);

      // 2: six transitions with ready low -> 4 queued, 2 dropped
      for (int i = 0; i < 6; i++) step("t2", cur + 2'd1, 1'b1, 1'b0);
      check("t2.drop", 32'(drop_cnt), 2);
      for (int i = 0; i < 4; i++) step("t2dr", cur, 1'b1, 1'b1);
      check("t2.empty", 32'(evt_valid), 0);
      step("t2", cur + 2'd1, 1'b1, 1'b1);
      check("t2.lost1", 32'(evt_lost), 1);
      step("t2", cur + 2'd1, 1'b1, 1'b1);
      check("t2.lost0", 32'(evt_lost), 0);
      step("t2dr", cur, 1'b1, 1'b1);

      // 3: full FIFO, pop and push in the same cycle
      for (int i = 0; i < 4; i++) step("t3", cur + 2'd1, 1'b1, 1'b0);
      step("t3pp", cur + 2'd1, 1'b1, 1'b1);
      check("t3.drop", 32'(drop_cnt), 2);
      for (int i = 0; i < 4; i++) step("t3dr", cur, 1'b1, 1'b1);
      check("t3.drained", 32'(evt_valid), 0);

      // 4: long dwell saturates; timeout when compiled in
      for (int i = 0; i < 300; i++) step("t4", cur, 1'b1, 1'b1);
      step("t4", cur + 2'd1, 1'b1, 1'b0);
      check("t4.dwell", 32'(evt_dwell), 255);
      step("t4", cur, 1'b1, 1'b1);

      // 5: enable low across changes -> no event, dwell frozen at 1
      for (int i = 0; i < 10; i++) step("t5", cur + 2'd1, 1'b0, 1'b1);
      check("t5.noevt", 32'(evt_valid), 0);
      step("t5", cur + 2'd1, 1'b1, 1'b0);
      check("t5.dwell", 32'(evt_dwell), 2);
      step("t5", cur, 1'b1, 1'b1);

      // 6: reset with three events queued
      for (int i = 0; i < 3; i++) step("t6", cur + 2'd1, 1'b1, 1'b0);
      check("t6.qd", 32'(evt_valid), 1);
      do_reset();
      check("t6.valid", 32'(evt_valid), 0);
      check("t6.drop", 32'(drop_cnt), 0);
      step("t6", cur, 1'b1, 1'b0);
      step("t6", cur, 1'b1, 1'b0);
      step("t6", cur + 2'd1, 1'b1, 1'b0);
      check("t6.dwell", 32'(evt_dwell), 3);

      // Randomized traffic
      for (int i = 0; i < 500; i++) begin
         logic [1:0] nst;
         nst = ($urandom_range(0, 1) == 0) ? cur : 2'($urandom_range(0, 3));
         step("rand", nst, $urandom_range(0, 9) != 0, $urandom_range(0, 9) < 5);
      end
      for (int i = 0; i < 6; i++) step("final", cur, 1'b1, 1'b1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
